// File: rtl/johnson_decoder_if.sv
// Purpose: sample/result bundle between a Johnson-code source and johnson_decoder.
// Ports (signals):
//   code_in[3:0], code_valid, err_clear        -- sample side, driven by the master
//   index[2:0], index_valid, dir[1:0],
//   illegal_code, seq_error, locked,
//   err_count[7:0]                             -- decode results, driven by the slave
interface johnson_decoder_if;
  logic [3:0] code_in;
  logic       code_valid;
  logic       err_clear;
  logic [2:0] index;
  logic       index_valid;
  logic [1:0] dir;
  logic       illegal_code;
  logic       seq_error;
  logic       locked;
  logic [7:0] err_count;

  modport master (
    output code_in, code_valid, err_clear,
    input  index, index_valid, dir, illegal_code, seq_error, locked, err_count
  );

  modport slave (
    input  code_in, code_valid, err_clear,
    output index, index_valid, dir, illegal_code, seq_error, locked, err_count
  );
endinterface

// File: rtl/johnson_decoder.sv
// Purpose: decode sampled 4-bit Johnson code words into a position 0..7, track
//          the step direction, lock onto a well-behaved sequence and count
//          illegal words and illegal jumps (saturating).
// Ports:
//   clock        -- system clock, rising edge
//   reset        -- asynchronous active-low reset
//   bus (slave)  -- code_in/code_valid/err_clear in; index, index_valid, dir,
//                   illegal_code, seq_error, locked, err_count out (all registered)
module johnson_decoder (
  input  logic               clock,
  input  logic               reset,
  johnson_decoder_if.slave   bus
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned DIR_W = 2;
  localparam int unsigned CNT_W = 8;

  localparam logic [DIR_W-1:0] DIR_HOLD = 2'b00;
  localparam logic [DIR_W-1:0] DIR_UP   = 2'b01;
  localparam logic [DIR_W-1:0] DIR_DOWN = 2'b10;
  localparam logic [DIR_W-1:0] DIR_UNK  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;       // also serves as the previous legal index
  logic             index_valid_q, index_valid_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             code_legal_c;
  logic [IDX_W-1:0] code_idx_c;
  logic [IDX_W-1:0] delta_c;
  logic             is_step_c;
  logic [DIR_W-1:0] step_dir_c;

  // Johnson word to position lookup; the eight remaining words are illegal.
  always_comb begin
    code_legal_c = 1'b1;
    code_idx_c   = '0;
    unique case (bus.code_in)
      4'b0000: code_idx_c = 3'd0;
      4'b0001: code_idx_c = 3'd1;
      4'b0011: code_idx_c = 3'd2;
      4'b0111: code_idx_c = 3'd3;
      4'b1111: code_idx_c = 3'd4;
      4'b1110: code_idx_c = 3'd5;
      4'b1100: code_idx_c = 3'd6;
      4'b1000: code_idx_c = 3'd7;
      default: code_legal_c = 1'b0;
    endcase
  end

  // Modulo-8 difference to the previous index classifies hold/up/down/jump.
  always_comb begin
    delta_c    = IDX_W'(code_idx_c - index_q);
    is_step_c  = 1'b1;
    step_dir_c = DIR_UNK;
    unique case (delta_c)
      3'd0:    step_dir_c = DIR_HOLD;
      3'd1:    step_dir_c = DIR_UP;
      3'd7:    step_dir_c = DIR_DOWN;
      default: is_step_c  = 1'b0;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    index_valid_d = 1'b0;
    dir_d         = dir_q;
    illegal_d     = 1'b0;
    seq_err_d     = 1'b0;
    err_cnt_d     = err_cnt_q;

    if (bus.code_valid) begin
      if (!code_legal_c) begin
        state_d   = ST_UNLOCKED;
        illegal_d = 1'b1;
        dir_d     = DIR_UNK;
      end else begin
        index_d       = code_idx_c;
        index_valid_d = 1'b1;
        unique case (state_q)
          ST_UNLOCKED: begin
            state_d = ST_ACQUIRE;
            dir_d   = DIR_UNK;
          end
          ST_ACQUIRE: begin
            if (is_step_c) begin
              state_d = ST_LOCKED;
              dir_d   = step_dir_c;
            end else begin
              dir_d   = DIR_UNK;
            end
          end
          ST_LOCKED: begin
            if (is_step_c) begin
              dir_d     = step_dir_c;
            end else begin
              state_d   = ST_ACQUIRE;
              seq_err_d = 1'b1;
              dir_d     = DIR_UNK;
            end
          end
          default: begin
            state_d = ST_UNLOCKED;
            dir_d   = DIR_UNK;
          end
        endcase
      end
    end

    // Saturating error count; a clear wins over a same-edge increment.
    if ((illegal_d || seq_err_d) && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = CNT_W'(err_cnt_q + CNT_W'(1));
    end
    if (bus.err_clear) begin
      err_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_UNLOCKED;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      dir_q         <= DIR_UNK;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      dir_q         <= dir_d;
      illegal_q     <= illegal_d;
      seq_err_q     <= seq_err_d;
      locked_q      <= locked_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.index        = index_q;
  assign bus.index_valid  = index_valid_q;
  assign bus.dir          = dir_q;
  assign bus.illegal_code = illegal_q;
  assign bus.seq_error    = seq_err_q;
  assign bus.locked       = locked_q;
  assign bus.err_count    = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Purpose: self-checking bench for johnson_decoder. A table of sample vectors
//          with hand-derived expected outputs is pushed through a scoreboard
//          queue; saturation, clear and asynchronous reset are exercised by
//          hand-written sequences.
module tb_johnson_decoder;

  typedef struct packed {
    logic [2:0] idx;
    logic       iv;
    logic [1:0] dir;
    logic       ill;
    logic       seq;
    logic       lk;
    logic [7:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
    logic       clr;
    exp_t       exp;
  } vec_t;

  logic clock;
  logic reset;

  johnson_decoder_if bus ();

  johnson_decoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   vectors;
  int   miscompares;
  exp_t sb_q[$];
  vec_t tbl[$];

  function automatic exp_t mk(input logic [2:0] idx, input logic iv, input logic [1:0] dir,
                              input logic ill, input logic seq, input logic lk,
                              input logic [7:0] cnt);
    exp_t e;
    e.idx = idx; e.iv = iv; e.dir = dir; e.ill = ill; e.seq = seq; e.lk = lk; e.cnt = cnt;
    return e;
  endfunction

  task automatic add(input logic v, input logic [3:0] code, input logic clr, input exp_t e);
    vec_t t;
    t.valid = v; t.code = code; t.clr = clr; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic chk_field(input string tag, input string fld, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s %s: got %0d, expected %0d", tag, fld, act, exp);
    end
  endtask

  // Compare every output against one expected record.
  task automatic chk_all(input string tag, input exp_t e);
    vectors++;
    chk_field(tag, "index",        int'(bus.index),        int'(e.idx));
    chk_field(tag, "index_valid",  int'(bus.index_valid),  int'(e.iv));
    chk_field(tag, "dir",          int'(bus.dir),          int'(e.dir));
    chk_field(tag, "illegal_code", int'(bus.illegal_code), int'(e.ill));
    chk_field(tag, "seq_error",    int'(bus.seq_error),    int'(e.seq));
    chk_field(tag, "locked",       int'(bus.locked),       int'(e.lk));
    chk_field(tag, "err_count",    int'(bus.err_count),    int'(e.cnt));
    if ($isunknown({bus.index, bus.index_valid, bus.dir, bus.illegal_code,
                    bus.seq_error, bus.locked, bus.err_count})) begin
      miscompares++;
      $display("FAIL %s unknown: outputs contain X/Z", tag);
    end
  endtask

  // Drive one sample at the falling edge, queue its expectation, check after the rising edge.
  task automatic apply(input string tag, input logic v, input logic [3:0] code,
                       input logic clr, input exp_t e);
    exp_t got;
    @(negedge clock);
    bus.code_valid = v;
    bus.code_in    = code;
    bus.err_clear  = clr;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s scoreboard: queue empty, expected one entry", tag);
    end else begin
      got = sb_q.pop_front();
      chk_all(tag, got);
    end
  endtask

  localparam logic [1:0] H = 2'b00, U = 2'b01, D = 2'b10, X = 2'b11;

  initial begin
    int cnt_m;
    vectors     = 0;
    miscompares = 0;
    bus.code_in    = 4'b0000;
    bus.code_valid = 1'b0;
    bus.err_clear  = 1'b0;
    reset          = 1'b0;
    #12;
    chk_all("reset_state", mk(3'd0, 1'b0, X, 1'b0, 1'b0, 1'b0, 8'd0));
    @(negedge clock);
    reset = 1'b1;

    //   valid code     clr    idx  iv  dir ill seq lk cnt
    add(1'b1, 4'b0000, 1'b0, mk(3'd0, 1, X, 0, 0, 0, 8'd0));   // UNLOCKED -> ACQUIRE
    add(1'b1, 4'b0001, 1'b0, mk(3'd1, 1, U, 0, 0, 1, 8'd0));   // lock on up step
    add(1'b1, 4'b0011, 1'b0, mk(3'd2, 1, U, 0, 0, 1, 8'd0));
    add(1'b1, 4'b0111, 1'b0, mk(3'd3, 1, U, 0, 0, 1, 8'd0));
    add(1'b1, 4'b1111, 1'b0, mk(3'd4, 1, U, 0, 0, 1, 8'd0));
    add(1'b1, 4'b1110, 1'b0, mk(3'd5, 1, U, 0, 0, 1, 8'd0));
    add(1'b1, 4'b1100, 1'b0, mk(3'd6, 1, U, 0, 0, 1, 8'd0));
    add(1'b1, 4'b1000, 1'b0, mk(3'd7, 1, U, 0, 0, 1, 8'd0));
    add(1'b1, 4'b0000, 1'b0, mk(3'd0, 1, U, 0, 0, 1, 8'd0));   // 7 -> 0 is up
    add(1'b1, 4'b1000, 1'b0, mk(3'd7, 1, D, 0, 0, 1, 8'd0));   // 0 -> 7 is down
    add(1'b1, 4'b1000, 1'b0, mk(3'd7, 1, H, 0, 0, 1, 8'd0));   // hold
    add(1'b0, 4'b0101, 1'b0, mk(3'd7, 0, H, 0, 0, 1, 8'd0));   // invalid edge holds
    add(1'b1, 4'b1100, 1'b0, mk(3'd6, 1, D, 0, 0, 1, 8'd0));
    add(1'b1, 4'b1110, 1'b0, mk(3'd5, 1, D, 0, 0, 1, 8'd0));
    add(1'b1, 4'b0111, 1'b0, mk(3'd3, 1, X, 0, 1, 0, 8'd1));   // jump while locked
    add(1'b1, 4'b1111, 1'b0, mk(3'd4, 1, U, 0, 0, 1, 8'd1));   // ACQUIRE step -> LOCKED
    add(1'b1, 4'b0111, 1'b0, mk(3'd3, 1, D, 0, 0, 1, 8'd1));
    add(1'b1, 4'b0011, 1'b0, mk(3'd2, 1, D, 0, 0, 1, 8'd1));
    add(1'b1, 4'b0101, 1'b0, mk(3'd2, 0, X, 1, 0, 0, 8'd2));   // illegal word, index kept
    add(1'b1, 4'b0011, 1'b0, mk(3'd2, 1, X, 0, 0, 0, 8'd2));
    add(1'b1, 4'b0111, 1'b0, mk(3'd3, 1, U, 0, 0, 1, 8'd2));   // relock
    add(1'b1, 4'b0011, 1'b0, mk(3'd2, 1, D, 0, 0, 1, 8'd2));
    add(1'b1, 4'b0001, 1'b0, mk(3'd1, 1, D, 0, 0, 1, 8'd2));
    add(1'b1, 4'b1110, 1'b0, mk(3'd5, 1, X, 0, 1, 0, 8'd3));   // 1 -> 5 jump
    add(1'b0, 4'b0000, 1'b1, mk(3'd5, 0, X, 0, 0, 0, 8'd0));   // clear only the count
    add(1'b1, 4'b1111, 1'b0, mk(3'd4, 1, D, 0, 0, 1, 8'd0));   // was ACQUIRE: step locks
    add(1'b1, 4'b1101, 1'b0, mk(3'd4, 0, X, 1, 0, 0, 8'd1));
    add(1'b1, 4'b1101, 1'b0, mk(3'd4, 0, X, 1, 0, 0, 8'd2));   // illegal in UNLOCKED
    add(1'b1, 4'b0000, 1'b0, mk(3'd0, 1, X, 0, 0, 0, 8'd2));
    add(1'b1, 4'b1010, 1'b0, mk(3'd0, 0, X, 1, 0, 0, 8'd3));   // illegal in ACQUIRE
    add(1'b1, 4'b0001, 1'b0, mk(3'd1, 1, X, 0, 0, 0, 8'd3));
    add(1'b1, 4'b0111, 1'b0, mk(3'd3, 1, X, 0, 0, 0, 8'd3));   // jump in ACQUIRE: no seq_error
    add(1'b1, 4'b1111, 1'b0, mk(3'd4, 1, U, 0, 0, 1, 8'd3));

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("tbl[%0d]", i), tbl[i].valid, tbl[i].code, tbl[i].clr, tbl[i].exp);
    end

    // Saturation: 260 illegal samples from count 3.
    cnt_m = 3;
    for (int i = 0; i < 260; i++) begin
      cnt_m = (cnt_m < 255) ? cnt_m + 1 : 255;
      apply($sformatf("sat[%0d]", i), 1'b1, 4'b0101, 1'b0,
            mk(3'd4, 0, X, 1, 0, 0, 8'(cnt_m)));
    end
    apply("clr_vs_inc", 1'b1, 4'b0101, 1'b1, mk(3'd4, 0, X, 1, 0, 0, 8'd0));

    // Build err_count=3 and lock, then reset between edges.
    apply("pre_ill1", 1'b1, 4'b1001, 1'b0, mk(3'd4, 0, X, 1, 0, 0, 8'd1));
    apply("pre_ill2", 1'b1, 4'b1011, 1'b0, mk(3'd4, 0, X, 1, 0, 0, 8'd2));
    apply("pre_ill3", 1'b1, 4'b0100, 1'b0, mk(3'd4, 0, X, 1, 0, 0, 8'd3));
    apply("pre_acq",  1'b1, 4'b0011, 1'b0, mk(3'd2, 1, X, 0, 0, 0, 8'd3));
    apply("pre_lock", 1'b1, 4'b0111, 1'b0, mk(3'd3, 1, U, 0, 0, 1, 8'd3));
    @(negedge clock);
    bus.code_valid = 1'b1;
    bus.code_in    = 4'b1111;
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", mk(3'd0, 0, X, 0, 0, 0, 8'd0));
    @(posedge clock);
    #1;
    chk_all("reset_held", mk(3'd0, 0, X, 0, 0, 0, 8'd0));
    @(negedge clock);
    bus.code_valid = 1'b0;
    reset = 1'b1;

    apply("idle0", 1'b0, 4'b0011, 1'b0, mk(3'd0, 0, X, 0, 0, 0, 8'd0));
    apply("idle1", 1'b0, 4'b1111, 1'b1, mk(3'd0, 0, X, 0, 0, 0, 8'd0));
    apply("post_first", 1'b1, 4'b0001, 1'b0, mk(3'd1, 1, X, 0, 0, 0, 8'd0));
    apply("post_lock",  1'b1, 4'b0011, 1'b0, mk(3'd2, 1, U, 0, 0, 1, 8'd0));
    apply("post_hold",  1'b0, 4'b1010, 1'b0, mk(3'd2, 0, U, 0, 0, 1, 8'd0));

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001: clock  input  1  System clock; all state updates on the rising edge.
REQ-002: reset  input  1  Asynchronous, active-low reset; asserting (0) immediately forces the reset state; release is synchronous to the clock.
REQ-003: code_in  input  4  Sampled 4-bit Johnson code word from the counter under observation.
REQ-004: code_valid  input  1  code_in is sampled only on edges where code_valid=1.
REQ-005: err_clear  input  1  Synchronous clear of err_count only.
REQ-006: index  output  3  Decoded position 0..7 of the last legal code.
REQ-007: index_valid  output  1  Single-cycle pulse: index updated by the last sample.
REQ-008: dir  output  2  Step direction: 00 hold, 01 up, 10 down, 11 unknown.
REQ-009: illegal_code  output  1  Single-cycle pulse: last sample not a legal Johnson word.
REQ-010: seq_error  output  1  Single-cycle pulse: legal word but illegal jump while locked.
REQ-011: locked  output  1  High while the FSM is in LOCKED.
REQ-012: err_count  output  8  Saturating count of illegal_code plus seq_error events.

Function
REQ-013: Legal words and indices SHALL be: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7; the other 8 words SHALL be illegal.
REQ-014: "Up" SHALL be index+1 mod 8 (next word = {code[2:0], ~code[3]}); "down" index-1 mod 8; 7->0 is up, 0->7 is down.
REQ-015: All outputs SHALL be registered; each output reflects the sample taken one clock edge earlier (latency 1 cycle).
REQ-016: On a code_valid=0 edge, index, dir, locked, err_count and FSM state SHALL hold; index_valid, illegal_code, seq_error SHALL be 0.
REQ-017: A legal sample SHALL load index, pulse index_valid and store the word as the previous index; an illegal sample SHALL leave index and previous index unchanged.
REQ-018: FSM states SHALL be UNLOCKED, ACQUIRE, LOCKED.
REQ-019: UNLOCKED: legal -> ACQUIRE, dir=11; illegal -> stay, illegal_code=1.
REQ-020: ACQUIRE: legal step (hold/up/down vs. previous) -> LOCKED, dir set accordingly; legal jump -> stay ACQUIRE, dir=11, no seq_error; illegal -> UNLOCKED, illegal_code=1, dir=11.
REQ-021: LOCKED: legal step -> stay, dir set; legal jump -> ACQUIRE, seq_error=1, dir=11; illegal -> UNLOCKED, illegal_code=1, dir=11.
REQ-022: illegal_code and seq_error SHALL never assert on the same edge.
REQ-023: err_count SHALL increment by 1 per illegal_code or seq_error pulse and saturate at 255.
REQ-024: err_clear=1 SHALL set err_count to 0 on that edge, overriding a simultaneous increment; it SHALL not affect any other state.

Reset
REQ-025: While reset=0: state UNLOCKED, index=0, previous index=0, index_valid=0, dir=11, illegal_code=0, seq_error=0, locked=0, err_count=0.
REQ-026: Reset asserted mid-operation SHALL clear all state immediately regardless of clock; the first valid sample after release SHALL be treated as from UNLOCKED.

Verification
REQ-027: Reset, then valid 0000,0001,0011 -> index 0,1,2; locked=1 after 2nd sample; dir=01 after 2nd and 3rd; err_count=0.
REQ-028: Locked, up-count through 1000 then 0000 -> index 7 then 0, dir=01, no errors; reverse 0000->1000 -> dir=10, index 7.
REQ-029: Locked at 0011, apply 0101 -> illegal_code pulse, locked=0, index stays 2, err_count+1; then 0011,0111 -> relocks, dir=01.
REQ-030: Locked at 0001, apply 1110 -> seq_error pulse, state ACQUIRE, index=5, dir=11, err_count+1.
REQ-031: Force err_count=255 by 260 illegal samples -> stays 255; err_clear with simultaneous illegal sample -> err_count=0.
REQ-032: Assert reset between clock edges while locked with err_count=3 -> all outputs to reset values immediately; code_valid=0 cycles -> outputs hold, pulses low.
